// File: rtl/sector_server_pkg.sv
// Shared types and constants for the sector responder.
//   WORDS_PER_SECTOR : 512-byte sector seen as 16-bit words
//   word_t           : word index within a sector
//   ST_* / state_t   : FSM encodings (fixed values kept for legacy tooling)
package sector_server_pkg;

  localparam int WORDS_PER_SECTOR = 256;

  typedef logic [7:0] word_t;

  localparam word_t LAST_WORD = word_t'(WORDS_PER_SECTOR - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_FETCH = 3'd1;
  localparam logic [2:0] ST_RD_PUT   = 3'd2;
  localparam logic [2:0] ST_WR_ADDR  = 3'd3;
  localparam logic [2:0] ST_WR_CAP   = 3'd4;
  localparam logic [2:0] ST_WR_STORE = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    RD_FETCH = ST_RD_FETCH,
    RD_PUT   = ST_RD_PUT,
    WR_ADDR  = ST_WR_ADDR,
    WR_CAP   = ST_WR_CAP,
    WR_STORE = ST_WR_STORE,
    DONE     = ST_DONE
  } state_t;

endpackage

// File: rtl/bram_sector_server.sv
// bram_sector_server: responder side of the sd_lba/sd_rd/sd_wr/sd_ack sector
// protocol. Each transfer moves one 512-byte sector (256 x 16-bit words)
// between the core BRAM and an external word-addressed backing store.
//
// Ports
//   clk_sys, reset        clock, synchronous active-high reset
//   sd_lba/sd_rd/sd_wr    request (levels, held until sd_ack rises)
//   sd_ack                high for the whole transfer
//   sd_buff_addr/_dout/_wr/_din   core BRAM side (read strobes / write fetch)
//   st_addr/st_rd/st_wr/st_din/st_dout/st_ready   backing store handshake
//   oor_err               sticky out-of-range LBA flag
//
// Optional build macro SECTOR_SERVER_STATS_EN adds rd_cnt/wr_cnt, counting
// completed sectors per direction.
module bram_sector_server
  import sector_server_pkg::*;
#(
  parameter int SECTORS = 128,
  parameter int LBA_W   = 7,
  parameter int RD_LAT  = 1,   // must be >= 1
  parameter int GAP     = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [31:0]      sd_lba,
  input  logic             sd_rd,
  input  logic             sd_wr,
  output logic             sd_ack,
  output logic [7:0]       sd_buff_addr,
  output logic [15:0]      sd_buff_dout,
  output logic             sd_buff_wr,
  input  logic [15:0]      sd_buff_din,
  output logic [LBA_W+7:0] st_addr,
  output logic             st_rd,
  output logic             st_wr,
  output logic [15:0]      st_din,
  input  logic [15:0]      st_dout,
  input  logic             st_ready,
`ifdef SECTOR_SERVER_STATS_EN
  output logic [15:0]      rd_cnt,
  output logic [15:0]      wr_cnt,
`endif
  output logic             oor_err
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP);
  localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);

  state_t           state;
  word_t            word;
  logic [LBA_W-1:0] lba;
  logic             oor;       // current transfer targets a missing sector
  logic [15:0]      data;      // word in flight, either direction
  logic [7:0]       gap_cnt;
  logic [7:0]       lat_cnt;
`ifdef SECTOR_SERVER_STATS_EN
  logic             dir_rd;
`endif

  // Range test on the full 32-bit request so stray upper bits are caught.
  logic req_oor;
  assign req_oor = (sd_lba >= 32'(SECTORS));

  // NOTE: every output below is a pure decode of registered state through
  // continuous assigns, so there is no combinational path that could infer
  // a latch and reset values fall out of the register reset.
  assign sd_buff_addr = word;
  assign sd_buff_dout = data;
  assign sd_buff_wr   = (state == RD_PUT);
  assign st_addr      = {lba, word};
  assign st_din       = data;
  // Out-of-range transfers keep the full handshake timing towards the core
  // but never touch the store.
  assign st_rd        = (state == RD_FETCH) && !oor;
  assign st_wr        = (state == WR_STORE) && !oor;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      word    <= '0;
      lba     <= '0;
      oor     <= 1'b0;
      data    <= '0;
      gap_cnt <= GAP_LOAD;
      lat_cnt <= '0;
      sd_ack  <= 1'b0;
      oor_err <= 1'b0;
`ifdef SECTOR_SERVER_STATS_EN
      dir_rd  <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (sd_rd || sd_wr) begin
            lba     <= sd_lba[LBA_W-1:0];
            oor     <= req_oor;
            word    <= '0;
            lat_cnt <= '0;
            sd_ack  <= 1'b1;
            if (req_oor) oor_err <= 1'b1;
`ifdef SECTOR_SERVER_STATS_EN
            dir_rd  <= sd_rd;
`endif
            // Read wins when both requests are high.
            state   <= sd_rd ? RD_FETCH : WR_ADDR;
          end
        end

        RD_FETCH: begin
          if (oor) begin
            data  <= '0;
            state <= RD_PUT;
          end else if (st_ready) begin
            data  <= st_dout;
            state <= RD_PUT;
          end
        end

        RD_PUT: begin
          if (word == LAST_WORD) begin
            state <= DONE;
          end else begin
            word  <= word + 8'd1;
            state <= RD_FETCH;
          end
        end

        // sd_buff_addr already shows the new word; give the core BRAM
        // RD_LAT cycles before sampling its output.
        WR_ADDR: begin
          if (lat_cnt == LAT_LAST) state <= WR_CAP;
          else                     lat_cnt <= lat_cnt + 8'd1;
        end

        WR_CAP: begin
          data  <= sd_buff_din;
          state <= WR_STORE;
        end

        WR_STORE: begin
          if (oor || st_ready) begin
            lat_cnt <= '0;
            if (word == LAST_WORD) begin
              state <= DONE;
            end else begin
              word  <= word + 8'd1;
              state <= WR_ADDR;
            end
          end
        end

        DONE: begin
          sd_ack  <= 1'b0;
          gap_cnt <= GAP_LOAD;
          word    <= '0;
`ifdef SECTOR_SERVER_STATS_EN
          if (dir_rd) rd_cnt <= rd_cnt + 16'd1;
          else        wr_cnt <= wr_cnt + 16'd1;
`endif
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_sector_server.sv
// Directed bench for bram_sector_server: behavioural backing store with
// optional st_ready jitter, a registered core BRAM (RD_LAT=1) holding ~n,
// and a negedge monitor that records strobes and handshake activity.
module tb_bram_sector_server;

  localparam int LBA_W = 7;
  localparam int GAP   = 2;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic [31:0]      sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [7:0]       sd_buff_addr;
  logic [15:0]      sd_buff_dout;
  logic             sd_buff_wr;
  logic [15:0]      sd_buff_din = '0;
  logic [LBA_W+7:0] st_addr;
  logic             st_rd;
  logic             st_wr;
  logic [15:0]      st_din;
  logic [15:0]      st_dout;
  logic             st_ready;
  logic             oor_err;
`ifdef SECTOR_SERVER_STATS_EN
  logic [15:0]      rd_cnt;
  logic [15:0]      wr_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  bram_sector_server dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .st_addr      (st_addr),
    .st_rd        (st_rd),
    .st_wr        (st_wr),
    .st_din       (st_din),
    .st_dout      (st_dout),
    .st_ready     (st_ready),
`ifdef SECTOR_SERVER_STATS_EN
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt),
`endif
    .oor_err      (oor_err)
  );

  // Core BRAM: word n holds ~n, one cycle read latency.
  always @(posedge clk_sys) sd_buff_din <= ~{8'h00, sd_buff_addr};

  // Backing store: unwritten word a reads back as a itself.
  logic [15:0] mem     [32768];
  bit          written [32768];
  bit          jitter = 1'b0;
  logic        ready_gate = 1'b1;

  always @(posedge clk_sys) ready_gate <= jitter ? 1'($urandom_range(0, 1)) : 1'b1;

  assign st_ready = (st_rd | st_wr) & ready_gate;
  assign st_dout  = written[st_addr] ? mem[st_addr] : {1'b0, st_addr};

  // Monitor.
  logic [7:0]  got_addr [256];
  logic [15:0] got_data [256];
  int   strb_idx, tot_strb, st_rd_cyc, st_wr_acc, ack_rises, gap_viol, low_run;
  logic ack_q    = 1'b0;
  bit   had_fall = 1'b0;

  always @(negedge clk_sys) begin
    if (sd_ack && !ack_q) begin
      ack_rises++;
      strb_idx = 0;
      if (had_fall && low_run < GAP) gap_viol++;
    end
    if (!sd_ack && ack_q) had_fall = 1'b1;
    low_run = sd_ack ? 0 : low_run + 1;
    if (sd_buff_wr) begin
      if (strb_idx < 256) begin
        got_addr[strb_idx] = sd_buff_addr;
        got_data[strb_idx] = sd_buff_dout;
      end
      strb_idx++;
      tot_strb++;
    end
    if (st_rd) st_rd_cyc++;
    if (st_wr && st_ready) begin
      mem[st_addr]     = st_din;
      written[st_addr] = 1'b1;
      st_wr_acc++;
    end
    ack_q = sd_ack;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: raise the request, drop it once sd_ack rises, and
  // return at the negedge where sd_ack is first seen low again.
  task automatic run_xfer(input logic [31:0] lba, input logic rd, input logic wr,
                          input string tag);
    int t;
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    t = 0;
    while (!sd_ack && t < 100) begin @(negedge clk_sys); t++; end
    check({tag, " ack rise"}, 32'(sd_ack), 32'd1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    t = 0;
    while (sd_ack && t < 5000) begin @(negedge clk_sys); t++; end
    check({tag, " ack fall"}, 32'(sd_ack), 32'd0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk_sys);
    #1;
  endtask

  // Compare the last transfer's strobes against base+n (or all-zero).
  function automatic int seq_bad(input logic [15:0] base, input bit invert, input bit zero);
    int bad = 0;
    logic [15:0] exp;
    for (int i = 0; i < 256; i++) begin
      exp = zero ? 16'h0000 : (invert ? ~{8'h00, 8'(i)} : base + 16'(i));
      if (got_addr[i] !== 8'(i) || got_data[i] !== exp) bad++;
    end
    return bad;
  endfunction

  initial begin
    int s_strb, s_rd, s_wr, s_rise, s_viol, bad, t;
    logic [LBA_W+7:0] a;

    reset  = 1'b1;
    sd_lba = '0;
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst sd_ack",       32'(sd_ack),       32'd0);
    check("rst sd_buff_wr",   32'(sd_buff_wr),   32'd0);
    check("rst sd_buff_addr", 32'(sd_buff_addr), 32'd0);
    check("rst sd_buff_dout", 32'(sd_buff_dout), 32'd0);
    check("rst st_rd/st_wr",  32'({st_rd, st_wr}), 32'd0);
    check("rst st_addr",      32'(st_addr),      32'd0);
    check("rst oor_err",      32'(oor_err),      32'd0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Read LBA 3, store ready every cycle.
    s_strb = tot_strb; s_rd = st_rd_cyc;
    run_xfer(32'd3, 1'b1, 1'b0, "rd3");
    check("rd3 seq",        32'(seq_bad(16'h0300, 1'b0, 1'b0)), 32'd0);
    check("rd3 last data",  32'(got_data[255]), 32'h03FF);
    check("rd3 last addr",  32'(got_addr[255]), 32'hFF);
    settle();
    check("rd3 strobes",    32'(tot_strb - s_strb),  32'd256);
    check("rd3 st_rd cyc",  32'(st_rd_cyc - s_rd),   32'd256);

    // Core load sequence: LBA 0..127, request re-raised as soon as ack falls.
    s_strb = tot_strb; s_rise = ack_rises; s_viol = gap_viol;
    bad = 0;
    for (int l = 0; l < 128; l++) begin
      run_xfer(32'(l), 1'b1, 1'b0, "load");
      bad += seq_bad({1'b0, 7'(l), 8'h00}, 1'b0, 1'b0);
    end
    check("load data",      32'(bad), 32'd0);
    settle();
    check("load transfers", 32'(ack_rises - s_rise), 32'd128);
    check("load strobes",   32'(tot_strb - s_strb),  32'd32768);
    check("load gap viol",  32'(gap_viol - s_viol),  32'd0);

    // Write LBA 5 from core BRAM (~n), store with ready jitter.
    jitter = 1'b1;
    @(negedge clk_sys);
    s_strb = tot_strb; s_wr = st_wr_acc;
    run_xfer(32'd5, 1'b0, 1'b1, "wr5");
    settle();
    check("wr5 no strobes", 32'(tot_strb - s_strb), 32'd0);
    check("wr5 st_wr acc",  32'(st_wr_acc - s_wr),  32'd256);
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      a = {7'd5, 8'(n)};
      if (!written[a] || mem[a] !== ~{8'h00, 8'(n)}) bad++;
    end
    check("wr5 store data", 32'(bad), 32'd0);
    a = {7'd5, 8'd0};
    check("wr5 word0",      32'(mem[a]), 32'hFFFF);
    a = {7'd5, 8'd255};
    check("wr5 word255",    32'(mem[a]), 32'hFF00);

    // Read LBA 5 back, still with jitter.
    run_xfer(32'd5, 1'b1, 1'b0, "rb5");
    check("rb5 seq",        32'(seq_bad(16'h0000, 1'b1, 1'b0)), 32'd0);
    jitter = 1'b0;
    settle();

    // Out-of-range read LBA 200.
    check("oor_err before", 32'(oor_err), 32'd0);
    s_strb = tot_strb; s_rd = st_rd_cyc;
    run_xfer(32'd200, 1'b1, 1'b0, "oor rd");
    check("oor rd zeros",   32'(seq_bad(16'h0000, 1'b0, 1'b1)), 32'd0);
    settle();
    check("oor rd strobes", 32'(tot_strb - s_strb), 32'd256);
    check("oor rd no st_rd",32'(st_rd_cyc - s_rd),  32'd0);
    check("oor_err set",    32'(oor_err), 32'd1);

    // Out-of-range write: upper LBA bits set, low bits alias sector 3.
    s_strb = tot_strb; s_wr = st_wr_acc; s_rise = ack_rises;
    run_xfer(32'h0001_0003, 1'b0, 1'b1, "oor wr");
    settle();
    check("oor wr ran",     32'(ack_rises - s_rise), 32'd1);
    check("oor wr no st_wr",32'(st_wr_acc - s_wr),   32'd0);
    check("oor wr strobes", 32'(tot_strb - s_strb),  32'd0);

    // Both requests high: read wins.
    s_strb = tot_strb; s_wr = st_wr_acc;
    run_xfer(32'd3, 1'b1, 1'b1, "both");
    check("both seq",       32'(seq_bad(16'h0300, 1'b0, 1'b0)), 32'd0);
    settle();
    check("both strobes",   32'(tot_strb - s_strb), 32'd256);
    check("both no st_wr",  32'(st_wr_acc - s_wr),  32'd0);

    // Reset in the middle of a read of LBA 4, at word 100.
    sd_lba = 32'd4;
    sd_rd  = 1'b1;
    t = 0;
    while (!sd_ack && t < 100) begin @(negedge clk_sys); t++; end
    sd_rd = 1'b0;
    t = 0;
    while (sd_buff_addr != 8'd100 && t < 2000) begin @(negedge clk_sys); t++; end
    check("abort reached w100", 32'(sd_buff_addr), 32'd100);
    reset = 1'b1;
    @(negedge clk_sys);
    check("abort sd_ack",   32'(sd_ack), 32'd0);
    check("abort strobes",  32'({sd_buff_wr, st_rd, st_wr}), 32'd0);
    check("abort oor clr",  32'(oor_err), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    s_strb = tot_strb;
    run_xfer(32'd4, 1'b1, 1'b0, "post rst");
    check("post rst first", 32'(got_addr[0]), 32'd0);
    check("post rst seq",   32'(seq_bad(16'h0400, 1'b0, 1'b0)), 32'd0);
    settle();
    check("post rst strobes", 32'(tot_strb - s_strb), 32'd256);

`ifdef SECTOR_SERVER_STATS_EN
    // One read already completed since reset; add 2 writes and 2 reads.
    run_xfer(32'd6, 1'b0, 1'b1, "st w6");
    run_xfer(32'd7, 1'b0, 1'b1, "st w7");
    run_xfer(32'd8, 1'b1, 1'b0, "st r8");
    run_xfer(32'd9, 1'b1, 1'b0, "st r9");
    settle();
    check("rd_cnt", 32'(rd_cnt), 32'd3);
    check("wr_cnt", 32'(wr_cnt), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
